// File: rtl/ahb_slv_pkg.sv
// Shared definitions for the AHB-Lite slave write-buffer bridge:
// HTRANS/HRESP encodings, the bridge FSM states and the strobe/alignment helpers.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Widest supported bus is 64 bits, so strobes are built at 8 lanes and truncated.
  localparam int unsigned MAX_STRB_W = 8;

  // Little-endian byte-lane mask: 2^size lanes starting at lane.
  function automatic logic [MAX_STRB_W-1:0] gen_strb(input logic [2:0] size,
                                                     input logic [2:0] lane);
    logic [MAX_STRB_W-1:0] mask;
    case (size)
      3'd0:    mask = 8'h01;
      3'd1:    mask = 8'h03;
      3'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << lane;
  endfunction

  // Natural alignment of the address to the transfer size (sizes above 64 bits never align).
  function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (addr_lo[0] == 1'b0);
      3'd2:    ok = (addr_lo[1:0] == 2'b00);
      3'd3:    ok = (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_wbuf.sv
// Posted-write buffer: synchronous FIFO of (addr, data, strb) entries.
// Ports: i_push/i_pop with write-side fields in, head fields out, full/empty/level.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module ahb_wbuf #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned SW    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [AW-1:0]              i_addr,
  input  logic [DW-1:0]              i_data,
  input  logic [SW-1:0]              i_strb,
  output logic [AW-1:0]              o_addr,
  output logic [DW-1:0]              o_data,
  output logic [SW-1:0]              o_strb,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [SW-1:0] r_mem_strb [DEPTH];
  logic [PTR_W:0] r_wptr;
  logic [PTR_W:0] r_rptr;
  logic w_do_push;
  logic w_do_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_level = r_wptr - r_rptr;

  // A push into a full buffer is allowed when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer update
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem_addr[r_wptr[PTR_W-1:0]] <= i_addr;
      r_mem_data[r_wptr[PTR_W-1:0]] <= i_data;
      r_mem_strb[r_wptr[PTR_W-1:0]] <= i_strb;
    end
  end

  assign o_addr = r_mem_addr[r_rptr[PTR_W-1:0]];
  assign o_data = r_mem_data[r_rptr[PTR_W-1:0]];
  assign o_strb = r_mem_strb[r_rptr[PTR_W-1:0]];

endmodule

// File: rtl/ahb_slave_wbuf_bridge.sv
// AHB-Lite slave bridging onto a single valid/ready backend through a posted-write buffer.
// Ports: AHB slave side (i_hselx, i_hready, i_htrans, i_hwrite, i_hsize, i_haddr, i_hwdata,
//   o_hreadyout, o_hresp, o_hrdata); backend request (o_valid, o_rd0_wr1, o_addr, o_wr_data,
//   o_wr_strb, i_ready); read return (i_rd_valid, i_rd_data); o_wbuf_level occupancy.
// Macro AHB_SLV_ERR_RESP_EN: illegal transfers get a two-cycle ERROR response; otherwise
//   illegal writes are dropped and illegal reads return zero.
module ahb_slave_wbuf_bridge
  import ahb_slv_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          WBUF_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE = 'h1000
) (
  input  logic                          i_clk_ahb,
  input  logic                          i_rstn_ahb,
  input  logic                          i_hselx,
  input  logic                          i_hready,
  input  logic                          i_hwrite,
  input  logic [1:0]                    i_htrans,
  input  logic [2:0]                    i_hsize,
  input  logic [ADDR_WIDTH-1:0]         i_haddr,
  input  logic [DATA_WIDTH-1:0]         i_hwdata,
  output logic                          o_hreadyout,
  output logic                          o_hresp,
  output logic [DATA_WIDTH-1:0]         o_hrdata,
  output logic                          o_valid,
  output logic                          o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [DATA_WIDTH/8-1:0]       o_wr_strb,
  input  logic                          i_ready,
  input  logic                          i_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_rd_data,
  output logic [$clog2(WBUF_DEPTH):0]   o_wbuf_level
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);

  state_e                  r_state;
  state_e                  w_state_nxt;
  state_e                  w_decode;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [STRB_W-1:0]       r_strb;
  logic                    r_legal;
  logic [DATA_WIDTH-1:0]   r_hrdata;
  logic                    w_accept;
  logic                    w_legal;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_hreadyout;
  logic                    w_done;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_rd_cap;
  logic                    w_rd_zero;
  logic                    w_full;
  logic                    w_empty;
  logic [ADDR_WIDTH-1:0]   w_head_addr;
  logic [DATA_WIDTH-1:0]   w_head_data;
  logic [STRB_W-1:0]       w_head_strb;

  // Address-phase decode
  assign w_accept = i_hselx && i_hready &&
                    ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));
  assign w_offset = i_haddr - ADDR_BASE;
  assign w_legal  = (i_haddr >= ADDR_BASE) && (w_offset < ADDR_SIZE) &&
                    is_aligned(i_hsize, i_haddr[2:0]) && (i_hsize <= 3'(LANE_W));

  always_comb begin
    w_decode = ST_IDLE;
    if (w_legal) begin
      w_decode = i_hwrite ? ST_WR_DATA : ST_RD_REQ;
    end else begin
`ifdef AHB_SLV_ERR_RESP_EN
      w_decode = ST_ERR1;
`else
      w_decode = i_hwrite ? ST_WR_DATA : ST_RD_REQ;
`endif
    end
  end

  // Backend pops the buffer head whenever it is ready.
  assign w_pop = !w_empty && i_ready;

  // FSM state register
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // FSM next state and data-phase controls
  always_comb begin
    w_state_nxt = r_state;
    w_hreadyout = 1'b1;
    w_done      = 1'b0;
    w_push      = 1'b0;
    w_rd_cap    = 1'b0;
    w_rd_zero   = 1'b0;
    case (r_state)
      ST_IDLE: w_done = 1'b1;
      ST_WR_DATA: begin
        // Illegal writes are dropped without waiting for buffer space.
        w_hreadyout = !r_legal || !w_full || w_pop;
        w_push      = r_legal && w_hreadyout;
        w_done      = w_hreadyout;
      end
      ST_RD_REQ: begin
        w_hreadyout = 1'b0;
        if (!r_legal) begin
          w_rd_zero   = 1'b1;
          w_state_nxt = ST_RD_DONE;
        end else if (w_empty && i_ready) begin
          if (i_rd_valid) begin
            w_rd_cap    = 1'b1;
            w_state_nxt = ST_RD_DONE;
          end else begin
            w_state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        w_hreadyout = 1'b0;
        if (i_rd_valid) begin
          w_rd_cap    = 1'b1;
          w_state_nxt = ST_RD_DONE;
        end
      end
      ST_RD_DONE: w_done = 1'b1;
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: w_done = 1'b1;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_done) w_state_nxt = w_accept ? w_decode : ST_IDLE;
  end

  // Address-phase capture and read data register
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_addr   <= '0;
      r_strb   <= '0;
      r_legal  <= 1'b0;
      r_hrdata <= '0;
    end else begin
      if (w_accept && w_done) begin
        r_addr  <= i_haddr;
        r_strb  <= STRB_W'(gen_strb(i_hsize, 3'(i_haddr[LANE_W-1:0])));
        r_legal <= w_legal;
      end
      if (w_rd_cap)       r_hrdata <= i_rd_data;
      else if (w_rd_zero) r_hrdata <= '0;
    end
  end

  ahb_wbuf #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .SW    (STRB_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .i_clk   (i_clk_ahb),
    .i_rstn  (i_rstn_ahb),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_addr  (r_addr),
    .i_data  (i_hwdata),
    .i_strb  (r_strb),
    .o_addr  (w_head_addr),
    .o_data  (w_head_data),
    .o_strb  (w_head_strb),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_wbuf_level)
  );

  // Backend request: buffered writes first, a read only once the buffer has drained.
  always_comb begin
    o_valid   = 1'b0;
    o_rd0_wr1 = 1'b0;
    o_addr    = '0;
    o_wr_data = '0;
    o_wr_strb = '0;
    if (!w_empty) begin
      o_valid   = 1'b1;
      o_rd0_wr1 = 1'b1;
      o_addr    = w_head_addr;
      o_wr_data = w_head_data;
      o_wr_strb = w_head_strb;
    end else if ((r_state == ST_RD_REQ) && r_legal) begin
      o_valid = 1'b1;
      o_addr  = r_addr;
    end
  end

  assign o_hreadyout = w_hreadyout;
  assign o_hrdata    = r_hrdata;
`ifdef AHB_SLV_ERR_RESP_EN
  assign o_hresp = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign o_hresp = HRESP_OKAY;
`endif

endmodule
